alu_div: RTL

Multi-cycle 32-bit integer divider implementing the RV32M DIV, DIVU, REM and REMU operations for the rv32i core. It is the iterative, subtract-based counterpart to the single-cycle `add` datapath block. It sits beside the ALU in the execute stage. The core issues a request with a start pulse, stalls while `busy` is high, and writes back `result` on `done`. Latency is fixed for every operand combination.

---
 rtl/alu_div.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_div.sv
// -----------------------------------------------------------------------------
// alu_div : multi-cycle 32-bit integer divider for the RV32M DIV / DIVU /
//           REM / REMU instructions.
//
// Restoring radix-2 divider producing one quotient bit per clock, MSB first.
// Every request takes exactly 33 cycles from acceptance to `done`.
// 32 of those cycles are CALC iterations, and 1 is the FIX cycle.
// The FIX cycle does sign correction and applies the RISC-V special cases:
// divide by zero, and signed overflow.
//
// Ports
//   clk     in   1   rising-edge clock
//   rst_n   in   1   asynchronous active-low reset
//   start   in   1   request strobe, only sampled while idle
//   op      in   2   00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
//   a       in  32   dividend (rs1)
//   b       in  32   divisor  (rs2)
//   busy    out  1   high from the cycle after acceptance until done
//   done    out  1   one-cycle completion pulse
//   result  out 32   quotient or remainder, held until the next completion
// -----------------------------------------------------------------------------
module alu_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Two's-complement negation.
    function automatic logic [31:0] neg32(input logic [31:0] x);
        neg32 = (~x) + 32'd1;
    endfunction

    // Magnitude of a signed 32-bit value.
    // 0x80000000 maps to itself, which reads correctly as unsigned 2^31.
    function automatic logic [31:0] abs32(input logic [31:0] x);
        if (x[31]) begin
            abs32 = neg32(x);
        end else begin
            abs32 = x;
        end
    endfunction

    // State and datapath registers
    state_t      state_r;
    logic [31:0] rem_r;       // partial remainder
    logic [31:0] dvd_r;       // dividend shifting out, quotient shifting in
    logic [31:0] dvs_r;       // divisor magnitude
    logic [31:0] a_r;         // original dividend, the remainder for b == 0
    logic [4:0]  cnt_r;       // iteration counter, wraps 31 -> 0
    logic        q_neg_r;
    logic        r_neg_r;
    logic        sel_rem_r;   // op[1]: return remainder instead of quotient
    logic        div0_r;
    logic        ovf_r;

    // Acceptance-time operand conditioning
    logic        signed_op_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic        q_neg_s;
    logic        r_neg_s;
    logic        div0_s;
    logic        ovf_s;

    // One restoring iteration
    logic [32:0] shift_s;     // {rem, next dividend bit}
    logic [33:0] diff_s;      // extra bit carries the borrow
    logic        borrow_s;
    logic [31:0] rem_next_s;
    logic        q_bit_s;

    // Final result selection
    logic [31:0] quo_fix_s;
    logic [31:0] rem_fix_s;
    logic [31:0] res_fix_s;

    // Decode the request and form magnitudes and sign flags for a signed op.
    always_comb begin
        signed_op_s = ~op[0];
        div0_s      = (b == 32'd0);
        if (signed_op_s) begin
            a_mag_s = abs32(a);
            b_mag_s = abs32(b);
            q_neg_s = a[31] ^ b[31];
            r_neg_s = a[31];
            ovf_s   = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        end else begin
            a_mag_s = a;
            b_mag_s = b;
            q_neg_s = 1'b0;
            r_neg_s = 1'b0;
            ovf_s   = 1'b0;
        end
    end

    // Trial subtraction.
    // The shifted remainder can reach 33 bits, so the borrow is taken from bit 33.
    always_comb begin
        shift_s  = {rem_r, dvd_r[31]};
        diff_s   = {1'b0, shift_s} - {2'b00, dvs_r};
        borrow_s = diff_s[33];
        q_bit_s  = ~borrow_s;
        if (borrow_s) begin
            // shift_s < divisor < 2^32 here, so the low 32 bits hold all of it
            rem_next_s = shift_s[31:0];
        end else begin
            rem_next_s = diff_s[31:0];
        end
    end

    // Sign fix-up, then special-case override, then quotient/remainder select.
    always_comb begin
        if (q_neg_r) begin
            quo_fix_s = neg32(dvd_r);
        end else begin
            quo_fix_s = dvd_r;
        end
        if (r_neg_r) begin
            rem_fix_s = neg32(rem_r);
        end else begin
            rem_fix_s = rem_r;
        end
        if (div0_r) begin
            quo_fix_s = 32'hFFFF_FFFF;
            rem_fix_s = a_r;
        end else if (ovf_r) begin
            quo_fix_s = 32'h8000_0000;
            rem_fix_s = 32'd0;
        end else begin
            quo_fix_s = quo_fix_s;
            rem_fix_s = rem_fix_s;
        end
        if (sel_rem_r) begin
            res_fix_s = rem_fix_s;
        end else begin
            res_fix_s = quo_fix_s;
        end
    end

    // Control FSM and datapath registers, with registered busy/done/result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            rem_r     <= 32'd0;
            dvd_r     <= 32'd0;
            dvs_r     <= 32'd0;
            a_r       <= 32'd0;
            cnt_r     <= 5'd0;
            q_neg_r   <= 1'b0;
            r_neg_r   <= 1'b0;
            sel_rem_r <= 1'b0;
            div0_r    <= 1'b0;
            ovf_r     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        rem_r     <= 32'd0;
                        dvd_r     <= a_mag_s;
                        dvs_r     <= b_mag_s;
                        a_r       <= a;
                        cnt_r     <= 5'd0;
                        q_neg_r   <= q_neg_s;
                        r_neg_r   <= r_neg_s;
                        sel_rem_r <= op[1];
                        div0_r    <= div0_s;
                        ovf_r     <= ovf_s;
                        busy      <= 1'b1;
                        state_r   <= ST_CALC;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    rem_r <= rem_next_s;
                    dvd_r <= {dvd_r[30:0], q_bit_s};
                    cnt_r <= cnt_r + 5'd1;
                    if (cnt_r == 5'd31) begin
                        state_r <= ST_FIX;
                    end else begin
                        state_r <= ST_CALC;
                    end
                end
                ST_FIX: begin
                    result  <= res_fix_s;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
